// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, reset PC, and the fetch-stage
// state and FIFO entry types.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam int          ILEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    // RUN keeps every response; DRAIN discards responses fetched before a redirect.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries. The head entry is presented
// from storage registers, so a push becomes visible one cycle later.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign pop_ok = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited memory
// requests, in-order response buffering and redirect flush/drain.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output fetch_state_e    dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);

    // Handshakes: a transfer happens in any cycle where valid && ready; a
    // producer holds valid and payload stable until that cycle.

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    fetch_state_e    state;

    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_data;
    logic            pop;
    logic            push;
    logic            req_hs;
    logic [CW:0]     in_use;
    logic [CW-1:0]   inflight_after;
    logic [XLEN-1:0] target_pc;

    assign target_pc = redirect_pc & ~32'h0000_0003;
    assign pop       = instr_valid && instr_ready;

    // The slot being popped this cycle counts as free, which sustains one
    // instruction per cycle with DEPTH=2. A granted-but-unaccepted request
    // keeps its credit, so the request stays valid without a pop.
    assign in_use = {1'b0, fifo_count} - (CW + 1)'(pop) + {1'b0, outstanding};

    assign imem_req_valid = rst_n && !redirect_valid && (in_use < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign push           = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
    assign push_data      = '{pc: resp_pc, instr: imem_resp_instr};
    assign inflight_after = outstanding - CW'(imem_resp_valid);

    assign instr_valid = (fifo_count != '0);
    assign instr       = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign dbg_state   = state;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            state       <= ST_RUN;
        end else if (redirect_valid) begin
            // Every fetch still in flight belongs to the old path.
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            outstanding <= inflight_after;
            drop_cnt    <= inflight_after;
            state       <= (inflight_after != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            if (req_hs) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_hs) - CW'(imem_resp_valid);
            if (imem_resp_valid) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                    if (drop_cnt == CW'(1)) begin
                        state <= ST_RUN;
                    end
                end else begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

endmodule
